stepper_motion_ctrl: RTL and testbench

Move-command controller for the stepper phase sequencer. It accepts "move N steps in direction D" commands and generates the sequencer's step_clk (one level toggle per step) and direction inputs. Step spacing follows a trapezoidal accel/cruise/decel profile measured in clk cycles. It sits between the robot motion-command logic and the per-motor phase sequencer.

---
 rtl/stepper_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_stepper_motion_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_motion_ctrl.sv
// Move-command controller: turns "N steps in direction D" commands into
// step_clk/direction for the phase sequencer using a trapezoidal
// accel/cruise/decel step-interval profile measured in clk cycles.
module stepper_motion_ctrl #(
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned PER_W        = 16,
  parameter int unsigned START_PERIOD = 8,
  parameter int unsigned MIN_PERIOD   = 4,
  parameter int unsigned ACCEL_DEC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              abort,
  output logic              step_clk_out,
  output logic              direction_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_remaining,
  output logic [PER_W-1:0]  cur_period
);

  localparam int unsigned PW1 = PER_W + 1;
  localparam logic [PER_W:0]   START_X = PW1'(START_PERIOD);
  localparam logic [PER_W:0]   MIN_X   = PW1'(MIN_PERIOD);
  localparam logic [PER_W:0]   DEC_X   = PW1'(ACCEL_DEC);
  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

  state_e              state_q, state_d;
  logic                step_clk_q, step_clk_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                abort_pend_q, abort_pend_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [STEP_W-1:0]   ramp_q, ramp_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [PER_W-1:0]    cnt_q, cnt_d;

  logic [PER_W:0]      sum_x, diff_x;
  logic [PER_W-1:0]    per_up, per_dn;
  logic [STEP_W-1:0]   r, lim;
  logic                step_evt;

  assign cmd_ready       = (state_q == IDLE);
  assign step_clk_out    = step_clk_q;
  assign direction_out   = dir_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign steps_remaining = rem_q;
  assign cur_period      = per_q;

  // Next-state: command accept, period counting, step-event profile updates, abort.
  always_comb begin
    state_d      = state_q;
    step_clk_d   = step_clk_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    rem_d        = rem_q;
    ramp_d       = ramp_q;
    per_d        = per_q;
    cnt_d        = cnt_q;
    lim          = '0;
    r            = rem_q - STEP_W'(1);
    sum_x        = {1'b0, per_q} + DEC_X;
    diff_x       = {1'b0, per_q} - DEC_X;
    per_up       = (sum_x > START_X) ? START_P : sum_x[PER_W-1:0];
    per_dn       = (diff_x[PER_W] || (diff_x < MIN_X)) ? MIN_P : diff_x[PER_W-1:0];
    step_evt     = (state_q != IDLE) && (cnt_q == per_q - PER_W'(1));

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        dir_d        = cmd_dir;
        rem_d        = cmd_steps;
        per_d        = START_P;
        ramp_d       = '0;
        cnt_d        = '0;
        aborted_d    = 1'b0;
        abort_pend_d = 1'b0;
        if (cmd_steps == '0) done_d = 1'b1;
        else                 state_d = ACCEL;
      end
    end else begin
      cnt_d = cnt_q + PER_W'(1);
      if (step_evt) begin
        step_clk_d = ~step_clk_q;
        cnt_d      = '0;
        rem_d      = r;
        if (r == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if ((state_q != DECEL) && (r <= ramp_q)) begin
          state_d = DECEL;
          per_d   = per_up;
        end else begin
          unique case (state_q)
            ACCEL: begin
              per_d  = per_dn;
              ramp_d = ramp_q + STEP_W'(1);
              if (per_dn == MIN_P) state_d = CRUISE;
            end
            DECEL:   per_d = per_up;
            default: ;
          endcase
        end
      end
      // Abort acts on the post-step values; only the ramp already built is unwound.
      if (abort) begin
        lim   = (rem_d < ramp_d) ? rem_d : ramp_d;
        rem_d = lim;
        if (lim == '0) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          state_d      = DECEL;
          abort_pend_d = 1'b1;
        end
      end
      if ((state_d == IDLE) && abort_pend_q) aborted_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      step_clk_q   <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      rem_q        <= '0;
      ramp_q       <= '0;
      per_q        <= START_P;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_clk_q   <= step_clk_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      rem_q        <= rem_d;
      ramp_q       <= ramp_d;
      per_q        <= per_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Scoreboard bench for stepper_motion_ctrl: a step-level profile model
// predicts every output event (toggle and/or done) per command.
module tb_stepper_motion_ctrl;

  localparam int START = 8;
  localparam int MINP  = 4;
  localparam int DEC   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        step_clk_out, direction_out, busy, done, aborted;
  logic [15:0] steps_remaining, cur_period;

  typedef struct {
    int cyc; bit tog; bit dn; bit ab; int rem; int per; bit dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic prev_step = 1'b0;

  stepper_motion_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort),
    .step_clk_out(step_clk_out), .direction_out(direction_out), .busy(busy),
    .done(done), .aborted(aborted), .steps_remaining(steps_remaining),
    .cur_period(cur_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int c, input bit tog, input bit dn, input bit ab,
                      input int rem, input int per, input bit dir);
    exp_t e;
    e.cyc = c; e.tog = tog; e.dn = dn; e.ab = ab; e.rem = rem; e.per = per; e.dir = dir;
    exp_q.push_back(e);
  endtask

  // Step-level profile model; abort_at is the clk edge (after accept) sampling a one-cycle abort.
  task automatic model_cmd(input int acc, input int n, input bit dir, input int abort_at);
    int rem, per, ramp, ph, t, nxt, lim, a;
    bit pend;
    rem = n; per = START; ramp = 0; ph = 1; t = 0; pend = 1'b0; a = abort_at;
    if (n == 0) begin
      push(acc, 1'b0, 1'b1, 1'b0, 0, START, dir);
      return;
    end
    forever begin
      nxt = t + per;
      if (a > t && a < nxt) begin
        lim = (rem < ramp) ? rem : ramp;
        if (lim == 0) begin
          push(acc + a, 1'b0, 1'b1, 1'b1, 0, per, dir);
          return;
        end
        rem = lim; ph = 3; pend = 1'b1; a = 0;
      end
      t = nxt;
      rem = rem - 1;
      if (rem == 0) begin
        push(acc + t, 1'b1, 1'b1, pend || (a == t), 0, per, dir);
        return;
      end
      if (ph != 3 && rem <= ramp) begin
        ph = 3; per = (per + DEC > START) ? START : per + DEC;
      end else if (ph == 1) begin
        per = (per - DEC < MINP) ? MINP : per - DEC;
        ramp++;
        if (per == MINP) ph = 2;
      end else if (ph == 3) begin
        per = (per + DEC > START) ? START : per + DEC;
      end
      if (a == t) begin
        a = 0;
        lim = (rem < ramp) ? rem : ramp;
        if (lim == 0) begin
          push(acc + t, 1'b1, 1'b1, 1'b1, 0, per, dir);
          return;
        end
        rem = lim; ph = 3; pend = 1'b1;
      end
      push(acc + t, 1'b1, 1'b0, 1'b0, rem, per, dir);
    end
  endtask

  // Hold a command until accepted (cmd_valid stays high while busy), then optionally pulse abort.
  task automatic issue(input int n, input bit dir, input int abort_at);
    bit rdy;
    int acc, guard;
    guard = 0;
    cmd_steps = 16'(n);
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    forever begin
      rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      guard++;
      if (guard > 3000) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: cmd_ready stayed %0d, required 1", cmd_ready);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_steps = 16'($urandom_range(0, 65535));
    model_cmd(acc, n, dir, abort_at);
    if (abort_at > 0) begin
      while (cyc < acc + abort_at - 1) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  // Monitor: every toggle or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && ((step_clk_out !== prev_step) || done)) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_event: toggle=%0d done=%0d at cycle %0d, required no event",
                 step_clk_out !== prev_step, done, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", cyc, mon_e.cyc);
        check("toggle", longint'(step_clk_out !== prev_step), longint'(mon_e.tog));
        check("done", done, mon_e.dn);
        check("aborted", aborted, mon_e.ab);
        check("busy", busy, !mon_e.dn);
        check("steps_remaining", steps_remaining, mon_e.rem);
        check("cur_period", cur_period, mon_e.per);
        check("direction", direction_out, mon_e.dir);
      end
    end
    prev_step <= step_clk_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ab, guard;
    bit d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_step_clk", step_clk_out, 0);
    check("rst_direction", direction_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_steps_remaining", steps_remaining, 0);
    check("rst_cur_period", cur_period, START);
    check("rst_cmd_ready", cmd_ready, 1);
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_step_clk", step_clk_out, 0);
    check("idle_busy", busy, 0);

    issue(10, 1'b0, 0);
    issue(3, 1'b1, 0);
    issue(1, 1'b0, 0);
    issue(0, 1'b1, 0);
    issue(100, 1'b0, 16);
    issue(50, 1'b1, 3);
    issue(2, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1;
      end
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 25));
      d  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * 5 + 10)) : 0;
      issue(n, d, ab);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin @(posedge clk); #1; guard++; end
    check("pending_events", exp_q.size(), 0);

    // Reset in the middle of a move with step_clk high.
    mon_en = 1'b0;
    issue(20, 1'b1, 0);
    exp_q.delete();
    guard = 0;
    while (step_clk_out !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    check("pre_reset_step_clk", step_clk_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_step_clk", step_clk_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_direction", direction_out, 0);
    check("midrst_steps_remaining", steps_remaining, 0);
    check("midrst_cur_period", cur_period, START);
    check("midrst_cmd_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
